// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface fetch_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two circular queue of fetch entries with occupancy count and synchronous clear.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = fetch_pkg::fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  entry_t                     wdata,
    input  logic                       pop,
    output entry_t                     rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; count and pointers alone decide which slots are valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: credit-limited imem requests, in-order response queue, redirect flush.
// Optional FETCH_BUFFER_BYPASS_EN: an empty queue forwards a live response straight to decode.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   redirect_pc,
    fetch_buffer_if.master    imem,
    output logic              valid_F,
    output logic [31:0]       instr_F,
    output logic [XLEN-1:0]   pc_F
);
    localparam int unsigned     CW      = $clog2(DEPTH+1);
    localparam int unsigned     OW      = $clog2(MAX_OUTSTANDING+1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   outstanding_next;
    logic [OW-1:0]   discard;
    logic [CW-1:0]   count;
    entry_t          head;
    entry_t          push_entry;
    logic            credit_ok;
    logic            issue;
    logic            accept;
    logic            bypass;
    logic            push;
    logic            pop;
    logic            head_valid;

    // Queue slots already held plus slots promised to in-flight requests must never exceed DEPTH.
    assign credit_ok = (int'(count) + int'(outstanding) < int'(DEPTH)) &&
                       (int'(outstanding) < int'(MAX_OUTSTANDING));

    assign imem.imem_req  = reset & ~flush & credit_ok;
    assign imem.imem_addr = fetch_pc;
    assign issue          = imem.imem_req & imem.imem_ready;

    assign accept     = imem.imem_rvalid & ~flush & (discard == '0);
    assign head_valid = (count != '0);
`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = ~head_valid & accept & ~stall;
`else
    assign bypass = 1'b0;
`endif
    assign push       = accept & ~bypass;
    assign pop        = head_valid & ~stall & ~flush;
    assign push_entry = '{pc: resp_pc, instr: imem.imem_rdata};

    assign outstanding_next = outstanding + OW'(issue) - OW'(imem.imem_rvalid);

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        valid_F = head_valid;
        instr_F = NOP_INSTR;
        pc_F    = resp_pc;
        if (head_valid) begin
            instr_F = head.instr;
            pc_F    = head.pc;
        end else if (bypass) begin
            valid_F = 1'b1;
            instr_F = imem.imem_rdata;
        end
    end

    // A flush re-targets both PCs and marks every request still in flight after this edge as stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (flush) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                discard  <= outstanding_next;
            end else begin
                if (issue)  fetch_pc <= fetch_pc + PC_STEP;
                if (accept) resp_pc  <= resp_pc + PC_STEP;
                if (imem.imem_rvalid && discard != '0) discard <= discard - OW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized self-checking bench for fetch_buffer against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_fetch_buffer;
    import fetch_pkg::*;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        valid_F;
    logic [31:0] instr_F;
    logic [31:0] pc_F;

    fetch_buffer_if #(.XLEN(XLEN)) imem ();

    fetch_buffer #(
        .XLEN            (XLEN),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .valid_F     (valid_F),
        .instr_F     (instr_F),
        .pc_F        (pc_F)
    );

    always #5 clk = ~clk;

    // Model: in-flight requests tagged with the redirect epoch they were issued in.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } req_t;

    req_t        pend[$];
    int          epoch = 0;
    int          in_queue = 0;
    int          consumed = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    logic        prev_hold = 1'b0;
    logic        prev_flush = 1'b0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    logic [31:0] prev_addr = '0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000 ^ {addr[9:2], 24'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h @%0t", tag, got, want, $time);
        end
    endtask

    task automatic clear_history();
        prev_hold  = 1'b0;
        prev_flush = 1'b0;
        prev_wait  = 1'b0;
    endtask

    // One clock: drive at the falling edge, check combinational outputs, advance the model.
    task automatic cycle(input logic st, input logic fl, input logic [31:0] rpc,
                         input logic rdy, input logic rsp);
        logic exp_req;
        req_t r;
        @(negedge clk);
        stall            = st;
        flush            = fl;
        redirect_pc      = rpc;
        imem.imem_ready  = rdy;
        imem.imem_rvalid = rsp && (pend.size() > 0);
        imem.imem_rdata  = (pend.size() > 0) ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
        #1;
        exp_req = !fl && (in_queue + pend.size() < DEPTH) && (pend.size() < MAXO);
        check("imem_req", imem.imem_req, exp_req);
        check("valid_F", valid_F, in_queue > 0);
        if (!valid_F) check("nop", instr_F, NOP_INSTR);
        if (prev_flush) check("valid_after_flush", valid_F, 1'b0);
        if (prev_hold) begin
            check("hold_pc", pc_F, prev_pc);
            check("hold_instr", instr_F, prev_instr);
        end
        if (prev_wait) check("addr_held", imem.imem_addr, prev_addr);

        if (valid_F && !st && !fl) begin
            check("pc_F", pc_F, exp_pc);
            check("instr_F", instr_F, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            in_queue--;
            consumed++;
        end
        if (imem.imem_rvalid) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !fl) in_queue++;
        end
        if (imem.imem_req && rdy) begin
            check("imem_addr", imem.imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            pend.push_back('{addr: imem.imem_addr, epoch: epoch});
        end

        prev_hold  = valid_F && st && !fl;
        prev_pc    = pc_F;
        prev_instr = instr_F;
        prev_wait  = imem.imem_req && !rdy;
        prev_addr  = imem.imem_addr;
        prev_flush = fl;
        if (fl) begin
            epoch++;
            in_queue  = 0;
            exp_pc    = rpc;
            exp_fetch = rpc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset            = 1'b0;
        stall            = 1'b0;
        flush            = 1'b0;
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b0;
        #1;
        check("rst_req", imem.imem_req, 1'b0);
        check("rst_valid", valid_F, 1'b0);
        check("rst_instr", instr_F, NOP_INSTR);
        check("rst_pc", pc_F, RESET_PC);
        check("rst_addr", imem.imem_addr, RESET_PC);
        @(posedge clk);
        @(posedge clk);
        pend.delete();
        epoch++;
        in_queue  = 0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        clear_history();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("first_req", imem.imem_req, 1'b1);
        check("first_addr", imem.imem_addr, RESET_PC);
        check("first_valid", valid_F, 1'b0);
    endtask

    initial begin
        int  c0;
        bit  found;
        imem.imem_ready  = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;

        do_reset();

        // Steady stream: 1-cycle memory, no stall.
        c0 = consumed;
        repeat (20) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("throughput", consumed - c0, 18);

        // Decode stall fills the queue until credits run out, then drains in order.
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        check("stall_req_off", imem.imem_req, 1'b0);
        c0 = consumed;
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("drain_count", consumed - c0, 4);

        // Redirect with two requests in flight; both late responses must vanish.
        check("two_inflight", pend.size(), 2);
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (valid_F) begin
                found = 1'b1;
                check("redirect_pc", pc_F, 32'h100);
            end
        end
        check("redirect_seen", found, 1'b1);

        // Flush while stalled and a response arrives in the same cycle.
        repeat (2) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Memory back-pressure holds the request address.
        repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);

        // PC wrap-around at the top of the address space.
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        c0 = consumed;
        repeat (10) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("wrap_count", consumed - c0, 8);
        check("wrap_next_pc", exp_pc, 32'h0000_0018);

        // Random traffic with a mid-stream reset.
        for (int n = 0; n < 900; n++) begin
            if (n == 450) do_reset();
            cycle($urandom_range(99) < 30,
                  $urandom_range(99) < 5,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(99) < 70,
                  $urandom_range(99) < 60);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction fetch stage with decoupling queue; sits directly upstream of the IF/ID pipeline register (stall/flush flop) and feeds it `{pc, instr}` pairs. Generates sequential fetch addresses to instruction memory, tracks in-flight requests, and buffers returned instructions so that a decode stall never drops or duplicates an instruction. A redirect from the hazard/branch logic flushes the queue and discards stale in-flight responses.

## Interface
- `XLEN`, 32: address/PC width
- `DEPTH`, 4: queue entries (power of two, ≥2)
- `MAX_OUTSTANDING`, 2: max in-flight imem requests
- `RESET_PC`, 0: first fetch address after reset
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-low reset
- `stall` in 1: decode not accepting; head held
- `flush` in 1: redirect request; priority over `stall`
- `redirect_pc` in XLEN: new fetch address, sampled when `flush`=1
- `imem_req` out 1: request valid
- `imem_addr` out XLEN: request address (= fetch_pc)
- `imem_ready` in 1: request accepted when `imem_req & imem_ready`
- `imem_rvalid` in 1: in-order response valid
- `imem_rdata` in 32: response instruction
- `valid_F` out 1: head entry valid
- `instr_F` out 32: head instruction; NOP (0x00000013) when `valid_F`=0
- `pc_F` out XLEN: head PC

## Operation
- State: `fetch_pc`, `resp_pc`, `outstanding` (0..MAX_OUTSTANDING), `discard` (≤ outstanding), queue of `{pc, instr}` with count 0..DEPTH.
- Issue: `imem_req` = ~flush & (count + outstanding < DEPTH) & (outstanding < MAX_OUTSTANDING). On handshake: `fetch_pc` += 4, `outstanding`++. `imem_addr` stable while `imem_req` & ~`imem_ready`.
- Response: `outstanding`--. If `discard`>0: `discard`--, data dropped. Else push `{resp_pc, imem_rdata}`, `resp_pc` += 4.
- Pop: `valid_F & ~stall` (same condition under which IF/ID captures).
- Credit rule guarantees no push when full; push+pop in one cycle allowed at any count.
- Flush: queue emptied; `fetch_pc`, `resp_pc` ← `redirect_pc`; no request issued that cycle; any response that cycle dropped; `discard` ← outstanding after this cycle's response retires (previous discards included).
- Arithmetic: PC increments mod 2^XLEN (wrap silent); counters sized `$clog2(N+1)`.
- Reset (async, any time): queue empty, `outstanding`=`discard`=0, `fetch_pc`=`resp_pc`=`RESET_PC`. Outputs: `imem_req`=0, `valid_F`=0, `instr_F`=NOP, `pc_F`=`RESET_PC`, `imem_addr`=`RESET_PC`.

## Timing
- First `imem_req` in first clock edge cycle after `reset` deasserts.
- Response → `valid_F`: 1 cycle (registered queue), 0 with bypass.
- Flush edge → first post-redirect request issued next cycle; `valid_F`=0 cycle after flush.
- Steady state with 1-cycle imem and `stall`=0: one instruction per cycle.
- `stall` held: `valid_F`, `instr_F`, `pc_F` stable.

## Configuration
- `FETCH_BUFFER_BYPASS_EN` defined: when queue empty, `imem_rvalid`=1, no discard pending and `stall`=0, response drives `instr_F`/`pc_F`/`valid_F` combinationally and is not pushed (zero latency).
- Undefined: all outputs come from queue registers only; response visible next cycle.

## Structure
- Shared package `fetch_pkg`: `NOP_INSTR` constant, `fetch_entry_t` struct `{pc, instr}`.
- Sub-module `fetch_fifo`: storage, pointers, count, synchronous clear; parameterised on DEPTH and entry type.

## Test plan
- Reset low mid-stream, release → `valid_F`=0, `instr_F`=0x00000013, then `imem_req`=1, `imem_addr`=0x0.
- Imem ready=1, latency 1, `stall`=0 → `pc_F` 0x0,0x4,0x8,… one per cycle, data matching addresses.
- `stall`=1 for 6 cycles → `imem_req` drops when count+outstanding=4; release yields 4 entries in order, no loss/dup.
- Flush with 2 outstanding, `redirect_pc`=0x100 → both late responses dropped; next `valid_F` shows `pc_F`=0x100.
- Flush same cycle as `stall`=1 and `imem_rvalid`=1 → queue empty next cycle, response dropped.
- `imem_ready`=0 for 3 cycles → `imem_addr` held, `fetch_pc` unchanged; `fetch_pc`=0xFFFFFFFC wraps to 0x0.
